magnitude_estimator_pipe: RTL and testbench

Pipelined, parametrised complex-magnitude estimator for the AGC datapath. It accepts signed I/Q samples over a valid/ready stream and computes an alpha-max-plus-beta-min approximation of |z|, with four run-time selectable coefficient modes. Arithmetic is saturating. It sits between the I/Q front end and the AGC gain loop, and replaces the single-mode combinational estimator. An optional smoothed-magnitude output feeds the gain-control loop directly.

---
 rtl/magnitude_estimator_pipe_if.sv | 24 ++
 rtl/magnitude_estimator_pipe.sv | 152 +++++++++++++++
 tb/tb_magnitude_estimator_pipe.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/magnitude_estimator_pipe_if.sv
// Valid/ready stream bundle for the magnitude estimator: I/Q samples in, magnitude out.
`timescale 1ns/1ps
interface magnitude_estimator_pipe_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_i;
    logic signed [DATA_W-1:0] in_q;
    logic [1:0]               mode;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_mag;

    modport master (
        output in_valid, in_i, in_q, mode, out_ready,
        input  in_ready, out_valid, out_mag
    );

    modport slave (
        input  in_valid, in_i, in_q, mode, out_ready,
        output in_ready, out_valid, out_mag
    );
endinterface

// File: rtl/magnitude_estimator_pipe.sv
// Three-stage saturating alpha-max-plus-beta-min |z| estimator with four coefficient modes.
// Optional smoothed output (out_avg) is built when MAG_AVG_EN is defined.
`timescale 1ns/1ps
module magnitude_estimator_pipe #(
    parameter int DATA_W    = 16,
    parameter int AVG_SHIFT = 4
) (
    input  logic clk,
    input  logic rst,
    magnitude_estimator_pipe_if.slave s
`ifdef MAG_AVG_EN
    ,
    output logic signed [DATA_W-1:0] out_avg
`endif
);
    localparam logic signed [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
        if (x == MIN_NEG)
            return MAX_POS;
        else if (x[DATA_W-1])
            return -x;
        else
            return x;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_mag(input logic [DATA_W:0] v);
        if (v > {1'b0, MAX_POS})
            return MAX_POS;
        else
            return v[DATA_W-1:0];
    endfunction

    // One extra bit of headroom; operands are non-negative so shifts are logical.
    function automatic logic [DATA_W:0] combine(input logic [1:0]        m,
                                                input logic [DATA_W-1:0] mx,
                                                input logic [DATA_W-1:0] mn);
        logic [DATA_W:0] ex;
        logic [DATA_W:0] en;
        logic [DATA_W:0] alt;
        ex  = {1'b0, mx};
        en  = {1'b0, mn};
        alt = ex - (ex >> 3) + (en >> 1);
        case (m)
            2'd0:    return ex + (en >> 1);
            2'd1:    return ex + (en >> 2);
            2'd2:    return ex + (en >> 2) + (en >> 3);
            default: return (alt > ex) ? alt : ex;
        endcase
    endfunction

    logic                     adv;
    logic                     vld_p0_q, vld_p0_d;
    logic                     vld_p1_q, vld_p1_d;
    logic                     vld_p2_q, vld_p2_d;
    logic signed [DATA_W-1:0] abs_i_p0_q, abs_i_p0_d;
    logic signed [DATA_W-1:0] abs_q_p0_q, abs_q_p0_d;
    logic [1:0]               mode_p0_q, mode_p0_d;
    logic signed [DATA_W-1:0] mx_p1_q, mx_p1_d;
    logic signed [DATA_W-1:0] mn_p1_q, mn_p1_d;
    logic [1:0]               mode_p1_q, mode_p1_d;
    logic signed [DATA_W-1:0] mag_p2_q, mag_p2_d;

    // A bubble at S3 or a consuming sink lets the whole pipe shift.
    assign adv        = !vld_p2_q || s.out_ready;
    assign s.in_ready = adv && !rst;
    assign s.out_valid = vld_p2_q;
    assign s.out_mag   = mag_p2_q;

    always_comb begin
        vld_p0_d   = vld_p0_q;
        vld_p1_d   = vld_p1_q;
        vld_p2_d   = vld_p2_q;
        abs_i_p0_d = abs_i_p0_q;
        abs_q_p0_d = abs_q_p0_q;
        mode_p0_d  = mode_p0_q;
        mx_p1_d    = mx_p1_q;
        mn_p1_d    = mn_p1_q;
        mode_p1_d  = mode_p1_q;
        mag_p2_d   = mag_p2_q;
        if (adv) begin
            // S1: absolute values
            vld_p0_d   = s.in_valid && s.in_ready;
            abs_i_p0_d = sat_abs(s.in_i);
            abs_q_p0_d = sat_abs(s.in_q);
            mode_p0_d  = s.mode;
            // S2: sort, ties keep |I| as the larger term
            vld_p1_d   = vld_p0_q;
            mode_p1_d  = mode_p0_q;
            if (abs_q_p0_q > abs_i_p0_q) begin
                mx_p1_d = abs_q_p0_q;
                mn_p1_d = abs_i_p0_q;
            end else begin
                mx_p1_d = abs_i_p0_q;
                mn_p1_d = abs_q_p0_q;
            end
            // S3: combine and saturate
            vld_p2_d   = vld_p1_q;
            mag_p2_d   = sat_mag(combine(mode_p1_q, $unsigned(mx_p1_q), $unsigned(mn_p1_q)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            mag_p2_q <= '0;
        end else begin
            vld_p0_q <= vld_p0_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            mag_p2_q <= mag_p2_d;
        end
        abs_i_p0_q <= abs_i_p0_d;
        abs_q_p0_q <= abs_q_p0_d;
        mode_p0_q  <= mode_p0_d;
        mx_p1_q    <= mx_p1_d;
        mn_p1_q    <= mn_p1_d;
        mode_p1_q  <= mode_p1_d;
    end

`ifdef MAG_AVG_EN
    localparam int AW = DATA_W + AVG_SHIFT;

    logic [AW-1:0]            acc_q, acc_d;
    logic signed [DATA_W-1:0] avg_q, avg_d;

    // Leaky integrator: acc settles at out_mag << AVG_SHIFT, so acc >> AVG_SHIFT is unbiased.
    always_comb begin
        acc_d = acc_q;
        avg_d = avg_q;
        if (vld_p2_q && s.out_ready) begin
            acc_d = acc_q + AW'($unsigned(mag_p2_q)) - (acc_q >> AVG_SHIFT);
            avg_d = acc_d[AW-1:AVG_SHIFT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end

    assign out_avg = avg_q;
`endif
endmodule

// File: tb/tb_magnitude_estimator_pipe.sv
// Scoreboard bench for magnitude_estimator_pipe: directed modes, saturation, stalls, reset, random stress.
`timescale 1ns/1ps
module tb_magnitude_estimator_pipe;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_in   = 0;
    int   n_out  = 0;
    logic [15:0] exp_q[$];

    magnitude_estimator_pipe_if #(.DATA_W(DATA_W)) bus ();
`ifdef MAG_AVG_EN
    logic signed [DATA_W-1:0] out_avg;
`endif

    magnitude_estimator_pipe #(.DATA_W(DATA_W), .AVG_SHIFT(4)) dut (
        .clk(clk),
        .rst(rst),
        .s  (bus)
`ifdef MAG_AVG_EN
        ,
        .out_avg(out_avg)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_mag(input int i, input int q, input int m);
        int ai, aq, mx, mn, r;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        if (ai > 32767) ai = 32767;
        if (aq > 32767) aq = 32767;
        mx = (aq > ai) ? aq : ai;
        mn = (aq > ai) ? ai : aq;
        case (m)
            0:       r = mx + mn / 2;
            1:       r = mx + mn / 4;
            2:       r = mx + mn / 4 + mn / 8;
            default: begin
                r = mx - mx / 8 + mn / 2;
                if (r < mx) r = mx;
            end
        endcase
        if (r > 32767) r = 32767;
        return 16'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    n_out++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: out_mag=%h with no sample outstanding", bus.out_mag);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.out_mag !== e) begin
                            errors++;
                            $display("FAIL sb_mag: out_mag=%h expected %h (output %0d)", bus.out_mag, e, n_out);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    n_in++;
                    exp_q.push_back(ref_mag(int'(bus.in_i), int'(bus.in_q), int'(bus.mode)));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_mag !== 16'h0000) begin
            errors++; $display("FAIL reset_out_mag: got %h expected 0000", bus.out_mag);
        end
`ifdef MAG_AVG_EN
        checks++;
        if (out_avg !== 16'h0000) begin
            errors++; $display("FAIL reset_out_avg: got %h expected 0000", out_avg);
        end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_modes();
        logic [15:0] want [4];
        int lat;
        want = '{16'h0580, 16'h04C0, 16'h0520, 16'h0500};
        bus.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            bus.in_i     = 16'sh0300;
            bus.in_q     = 16'shFC00;
            bus.mode     = 2'(m);
            bus.in_valid = 1'b1;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL mode%0d_ready: got %b expected 1", m, bus.in_ready);
            end
            tick();
            bus.in_valid = 1'b0;
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 8) begin
                tick();
                lat++;
            end
            checks++;
            if (lat != 3) begin
                errors++; $display("FAIL mode%0d_latency: got %0d cycles expected 3", m, lat);
            end
            checks++;
            if (bus.out_mag !== want[m]) begin
                errors++; $display("FAIL mode%0d_mag: got %h expected %h", m, bus.out_mag, want[m]);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        logic [15:0] vi [2];
        logic [15:0] vq [2];
        logic [1:0]  vm [2];
        int lat;
        vi = '{16'h8000, 16'h7FFF};
        vq = '{16'h8000, 16'h0000};
        vm = '{2'd0, 2'd2};
        bus.out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            bus.in_i     = vi[n];
            bus.in_q     = vq[n];
            bus.mode     = vm[n];
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 8) begin
                tick();
                lat++;
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_mag !== 16'h7FFF) begin
                errors++;
                $display("FAIL sat%0d_mag: got valid=%b mag=%h expected valid=1 mag=7fff", n, bus.out_valid, bus.out_mag);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int accepted = 0;
        int out_cnt = 0;
        int gaps = 0;
        logic [15:0] held;
        held = '0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.in_i = 16'(k * 64);
            bus.in_q = 16'(-(k * 32) - 5);
            bus.mode = 2'(k);
            #1;
            if (bus.in_ready) begin
                accepted++;
                k++;
            end
            tick();
            if (c == 2) held = bus.out_mag;
            if (c >= 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_mag !== held) begin
                    errors++;
                    $display("FAIL stall_hold_c%0d: got valid=%b mag=%h expected valid=1 mag=%h", c, bus.out_valid, bus.out_mag, held);
                end
            end
        end
        checks++;
        if (accepted != 3) begin
            errors++; $display("FAIL stall_accepts: got %0d accepts expected 3", accepted);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && out_cnt < 10; c++) begin
            if (k < 10) begin
                bus.in_valid = 1'b1;
                bus.in_i     = 16'(k * 64);
                bus.in_q     = 16'(-(k * 32) - 5);
                bus.mode     = 2'(k);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid) out_cnt++;
            else gaps++;
            if (bus.in_valid && bus.in_ready) k++;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (out_cnt != 10 || gaps != 0) begin
            errors++; $display("FAIL release_stream: got %0d outputs %0d gaps expected 10 outputs 0 gaps", out_cnt, gaps);
        end
    endtask

    task automatic test_reset_midstream();
        int lat;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in_i = 16'(1000 + c);
            bus.in_q = 16'(c);
            bus.mode = 2'd1;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_prefill: got out_valid=%b expected 1", bus.out_valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_mag !== 16'h0000) begin
            errors++; $display("FAIL flush_after_rst: got valid=%b mag=%h expected valid=0 mag=0000", bus.out_valid, bus.out_mag);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_stale_c%0d: got out_valid=%b expected 0", c, bus.out_valid);
            end
        end
        bus.in_i     = 16'sh0200;
        bus.in_q     = 16'sh0100;
        bus.mode     = 2'd0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 3 || bus.out_mag !== 16'h0280) begin
            errors++; $display("FAIL flush_new_sample: got latency=%0d mag=%h expected latency=3 mag=0280", lat, bus.out_mag);
        end
        tick();
    endtask

    task automatic test_random();
        int sent = 0;
        int budget = 0;
        int in0, out0;
        logic took = 1'b0;
        in0  = n_in;
        out0 = n_out;
        bus.in_valid = 1'b0;
        while (sent < 10000 && budget < 60000) begin
            if (!bus.in_valid || took) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_i     = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
                bus.in_q     = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
                bus.mode     = 2'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            took = bus.in_valid && bus.in_ready;
            if (took) sent++;
            tick();
            budget++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        budget = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (sent != 10000) begin
            errors++; $display("FAIL random_sent: got %0d accepts expected 10000", sent);
        end
        checks++;
        if ((n_out - out0) != (n_in - in0) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_count: got %0d outputs for %0d inputs, %0d outstanding", n_out - out0, n_in - in0, exp_q.size());
        end
    endtask

`ifdef MAG_AVG_EN
    task automatic test_avg();
        int xfers = 0;
        int acc_m = 0;
        logic was_xfer;
        logic [15:0] held;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_i      = 16'sh0100;
        bus.in_q      = 16'sh0000;
        bus.mode      = 2'd0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 80 && xfers < 48; c++) begin
            #1;
            was_xfer = bus.out_valid && bus.out_ready;
            tick();
            if (was_xfer) begin
                xfers++;
                acc_m = acc_m + 256 - (acc_m >> 4);
                if (xfers == 1) begin
                    checks++;
                    if (out_avg !== 16'h0010) begin
                        errors++; $display("FAIL avg_first: got %h expected 0010", out_avg);
                    end
                end
                checks++;
                if (out_avg !== 16'(acc_m >> 4)) begin
                    errors++; $display("FAIL avg_track_%0d: got %h expected %h", xfers, out_avg, 16'(acc_m >> 4));
                end
            end
        end
        checks++;
        if (xfers != 48 || $unsigned(out_avg) < 16'h00F0) begin
            errors++; $display("FAIL avg_converge: got %h after %0d transfers expected >= 00f0 after 48", out_avg, xfers);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        held = out_avg;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_avg !== held) begin
                errors++; $display("FAIL avg_hold_c%0d: got %h expected %h", c, out_avg, held);
            end
        end
        bus.out_ready = 1'b1;
        repeat (6) tick();
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_i      = '0;
        bus.in_q      = '0;
        bus.mode      = 2'd0;
        bus.out_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_modes();
        test_saturation();
        test_back_to_back();
        test_reset_midstream();
        test_random();
`ifdef MAG_AVG_EN
        test_avg();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
